// File: rtl/vga_sprite_engine.sv
// ============================================================================
// Module   : vga_sprite_engine
// Purpose  : Parametrised VGA timing generator with grid overlay and 1-bpp
//            sprite compositing from an on-chip, write-port-loaded bitmap RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_sprite_engine #(
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 0,
    parameter int NUM_SPRITES     = 4,
    parameter int SPRITE_SIZE     = 32,
    parameter int COLOR_BITS      = 3,
    parameter int GRID_SIZE       = 32,
    localparam int SEL_W          = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int ROW_W          = $clog2(SPRITE_SIZE)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SPRITES*10-1:0]           sprite_x,
    input  logic [NUM_SPRITES*10-1:0]           sprite_y,
    input  logic [NUM_SPRITES-1:0]              sprite_en,
    input  logic [NUM_SPRITES*3*COLOR_BITS-1:0] sprite_color,
    input  logic                                grid_en,
    input  logic                                wr_en,
    input  logic [SEL_W-1:0]                    wr_sprite,
    input  logic [ROW_W-1:0]                    wr_row,
    input  logic [SPRITE_SIZE-1:0]              wr_data,
    output logic [COLOR_BITS-1:0]               red,
    output logic [COLOR_BITS-1:0]               green,
    output logic [COLOR_BITS-1:0]               blue,
    output logic                                hsync,
    output logic                                vsync,
    output logic                                frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int CW      = 3 * COLOR_BITS;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT     = 11'(H_DISPLAY);
    localparam logic [10:0] V_ACT     = 11'(V_DISPLAY);
    localparam logic [10:0] HS_BEG    = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG    = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [10:0] SIZE11    = 11'(SPRITE_SIZE);
    localparam logic [10:0] GRID_MASK = 11'(GRID_SIZE - 1);
    localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_wrap;
    logic        frame_end;

    assign h_wrap    = (h_cnt == H_LAST);
    assign frame_end = h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // ------------------------------------------------------------------
    // Shadow sprite attributes, refreshed only at the frame boundary
    // ------------------------------------------------------------------
    logic [NUM_SPRITES-1:0][9:0]    sh_x;
    logic [NUM_SPRITES-1:0][9:0]    sh_y;
    logic [NUM_SPRITES-1:0]         sh_en;
    logic [NUM_SPRITES-1:0][CW-1:0] sh_color;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_en    <= '0;
            sh_color <= '0;
        end else if (frame_end) begin
            sh_x     <= sprite_x;
            sh_y     <= sprite_y;
            sh_en    <= sprite_en;
            sh_color <= sprite_color;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-sprite hit test and bitmap row fetch
    // ------------------------------------------------------------------
    logic [NUM_SPRITES-1:0] spr_on;

    generate
        for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
            logic [10:0]            x_left;
            logic [10:0]            y_top;
            logic                   hit_c;
            logic [ROW_W-1:0]       row_c;
            logic [ROW_W-1:0]       col_c;
            logic [SPRITE_SIZE-1:0] mem [SPRITE_SIZE];
            logic [SPRITE_SIZE-1:0] row_q;
            logic                   hit_q;
            logic [ROW_W-1:0]       col_q;
            logic [ROW_W-1:0]       bit_sel;

            // 11-bit compares so a sprite near the far edge clips instead of wrapping
            assign x_left = {1'b0, sh_x[i]};
            assign y_top  = {1'b0, sh_y[i]};
            assign hit_c  = sh_en[i]
                          && (h_cnt >= x_left) && (h_cnt < x_left + SIZE11)
                          && (v_cnt >= y_top)  && (v_cnt < y_top + SIZE11);
            assign row_c  = ROW_W'(v_cnt - y_top);
            assign col_c  = ROW_W'(h_cnt - x_left);

            // Read and write share one edge; the read sees the pre-write word
            always_ff @(posedge clk) begin
                row_q <= mem[row_c];
                if (wr_en && (wr_sprite == SEL_W'(i))) begin
                    mem[wr_row] <= wr_data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hit_q <= 1'b0;
                    col_q <= '0;
                end else begin
                    hit_q <= hit_c;
                    col_q <= col_c;
                end
            end

            // MSB is the leftmost pixel, so column c selects bit SIZE-1-c
            assign bit_sel   = ~col_q;
            assign spr_on[i] = hit_q && row_q[bit_sel];
        end
    endgenerate

    logic s1_valid;
    logic s1_active;
    logic s1_grid;
    logic s1_hs;
    logic s1_vs;
    logic s1_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_active <= 1'b0;
            s1_grid   <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_first  <= 1'b0;
        end else begin
            s1_valid  <= 1'b1;
            s1_active <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            s1_grid   <= ((h_cnt & GRID_MASK) == 11'd0) || ((v_cnt & GRID_MASK) == 11'd0);
            s1_hs     <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
            s1_vs     <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
            s1_first  <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority compositing and output registers
    // ------------------------------------------------------------------
    logic [CW-1:0] pix;

    always_comb begin
        pix = '0;
        if (s1_valid && s1_active) begin
            if (grid_en && s1_grid) begin
                pix = '1;
            end else begin
                // Scan high to low so the lowest-index sprite wins
                for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                    if (spr_on[i]) begin
                        pix = sh_color[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            red         <= pix[CW-1 -: COLOR_BITS];
            green       <= pix[2*COLOR_BITS-1 -: COLOR_BITS];
            blue        <= pix[COLOR_BITS-1:0];
            hsync       <= s1_hs ^ SYNC_IDLE;
            vsync       <= s1_vs ^ SYNC_IDLE;
            frame_start <= s1_valid && s1_first;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
// ============================================================================
// Module   : tb_vga_sprite_engine
// Purpose  : Directed self-checking bench for vga_sprite_engine on a reduced
//            raster (144x72 total, 128x64 visible).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_sprite_engine;

    localparam int HD = 128, HF = 4, HS = 8, HB = 4;
    localparam int VD = 64,  VF = 2, VS = 2, VB = 4;
    localparam int H_TOT = HD + HF + HS + HB;
    localparam int V_TOT = VD + VF + VS + VB;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] sprite_x = '0;
    logic [39:0] sprite_y = '0;
    logic [3:0]  sprite_en = '0;
    logic [35:0] sprite_color = '0;
    logic        grid_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sprite = '0;
    logic [4:0]  wr_row = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  red, green, blue;
    logic        hsync, vsync, frame_start;
    logic [8:0]  rgb;

    assign rgb = {red, green, blue};

    vga_sprite_engine #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(0), .NUM_SPRITES(4), .SPRITE_SIZE(32),
        .COLOR_BITS(3), .GRID_SIZE(32)
    ) dut (
        .clk(clk), .rst(rst),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .sprite_color(sprite_color), .grid_en(grid_en),
        .wr_en(wr_en), .wr_sprite(wr_sprite), .wr_row(wr_row), .wr_data(wr_data),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output raster position, re-anchored on every frame_start
    int o_h = 0, o_v = 0;
    logic synced = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            synced <= 1'b0;
        end else if (frame_start) begin
            o_h    <= 0;
            o_v    <= 0;
            synced <= 1'b1;
        end else if (synced) begin
            if (o_h == H_TOT - 1) begin
                o_h <= 0;
                o_v <= (o_v == V_TOT - 1) ? 0 : o_v + 1;
            end else begin
                o_h <= o_h + 1;
            end
        end
    end

    task automatic wait_pix(input int h, input int v);
        for (int n = 0; n < 2 * FRAME + 10; n++) begin
            @(negedge clk);
            #1;
            if (synced && o_h == h && o_v == v) return;
        end
        check("wait_pix_timeout", 32'd0, 32'd1);
    endtask

    task automatic pix_check(input string tag, input int h, input int v, input logic [8:0] exp);
        wait_pix(h, v);
        check(tag, {23'd0, rgb}, {23'd0, exp});
    endtask

    task automatic count_to_frame_start(output int cnt);
        cnt = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            cnt++;
            if (frame_start) return;
        end
    endtask

    initial begin
        int cnt;
        int hs_bad, vs_bad, rgb_bad, fs_bad;
        int h, v;
        logic exp_px;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rgb", {23'd0, rgb}, 32'd0);
        check("rst_hsync", {31'd0, hsync}, 32'd0);
        check("rst_vsync", {31'd0, vsync}, 32'd0);
        check("rst_frame_start", {31'd0, frame_start}, 32'd0);

        // Bitmaps: sprite 0 only row 3 = 0x0001C000, the others solid
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 32; r++) begin
                wr_en     = 1'b1;
                wr_sprite = 2'(s);
                wr_row    = 5'(r);
                wr_data   = (s == 0) ? ((r == 3) ? 32'h0001_C000 : 32'h0) : 32'hFFFF_FFFF;
                @(negedge clk);
            end
        end
        wr_en = 1'b0;

        sprite_x     = {10'd118, 10'd20, 10'd20, 10'd100};
        sprite_y     = {10'd0,   10'd10, 10'd10, 10'd50};
        sprite_en    = 4'b1111;
        sprite_color = {9'h16D, 9'h007, 9'h038, 9'h1C0};
        grid_en      = 1'b1;

        rst = 1'b0;
        count_to_frame_start(cnt);
        check("first_frame_start_latency", cnt, 32'd2);

        // Frame 0: shadows still cleared, so only timing and grid appear
        hs_bad = 0; vs_bad = 0; rgb_bad = 0; fs_bad = 0;
        for (int idx = 0; idx < FRAME; idx++) begin
            h = idx % H_TOT;
            v = idx / H_TOT;
            exp_px = (h < HD) && (v < VD) && ((h % 32 == 0) || (v % 32 == 0));
            if (hsync !== ((h >= HD + HF) && (h < HD + HF + HS))) hs_bad++;
            if (vsync !== ((v >= VD + VF) && (v < VD + VF + VS))) vs_bad++;
            if (rgb !== (exp_px ? 9'h1FF : 9'h000)) rgb_bad++;
            if (frame_start !== (idx == 0)) fs_bad++;
            @(negedge clk);
        end
        check("hsync_timing_errs", hs_bad, 32'd0);
        check("vsync_timing_errs", vs_bad, 32'd0);
        check("frame0_rgb_errs", rgb_bad, 32'd0);
        check("frame_start_extra", fs_bad, 32'd0);
        check("frame_period", {31'd0, frame_start}, 32'd1);
        grid_en = 1'b0;

        // Frame 1: shadows loaded at the previous frame boundary
        pix_check("edge_left", 118, 5, 9'h16D);
        pix_check("edge_last_col", 127, 5, 9'h16D);
        pix_check("edge_blank", 128, 5, 9'h000);
        pix_check("no_wrap_col0", 0, 6, 9'h000);
        pix_check("no_wrap_col21", 21, 6, 9'h000);
        pix_check("priority_green", 25, 15, 9'h038);
        wait_pix(0, 20);
        sprite_x[9:0] = 10'd60;
        pix_check("row2_empty", 115, 52, 9'h000);
        pix_check("spr0_left_of_bits", 114, 53, 9'h000);
        pix_check("spr0_px115", 115, 53, 9'h1C0);
        pix_check("spr0_px116", 116, 53, 9'h1C0);
        pix_check("spr0_px117", 117, 53, 9'h1C0);
        pix_check("spr0_right_of_bits", 118, 53, 9'h000);
        wait_pix(0, 60);
        grid_en = 1'b1;

        // Frame 2: moved sprite 0 and grid overlay
        pix_check("grid_over_sprite", 32, 20, 9'h1FF);
        pix_check("sprite_next_to_grid", 33, 20, 9'h038);
        pix_check("grid_col96", 96, 30, 9'h1FF);
        pix_check("moved_left_of_bits", 74, 53, 9'h000);
        pix_check("moved_px75", 75, 53, 9'h1C0);
        pix_check("moved_px77", 77, 53, 9'h1C0);
        pix_check("old_pos_clear", 115, 53, 9'h000);

        // Frame 3: reset mid-frame
        pix_check("pre_reset_grid", 32, 20, 9'h1FF);
        rst = 1'b1;
        #1;
        check("midrst_rgb", {23'd0, rgb}, 32'd0);
        check("midrst_hsync", {31'd0, hsync}, 32'd0);
        check("midrst_vsync", {31'd0, vsync}, 32'd0);
        grid_en = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_hold_rgb", {23'd0, rgb}, 32'd0);
        check("midrst_hold_fs", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        count_to_frame_start(cnt);
        check("restart_frame_start_latency", cnt, 32'd2);

        pix_check("post_rst_shadow_clear", 25, 15, 9'h000);
        pix_check("post_rst_spr0_off", 75, 53, 9'h000);
        pix_check("post_rst_next_frame", 75, 53, 9'h1C0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
